register_file: RTL and testbench

REGISTER_FILE -- requirements
Module: register_file

---
 rtl/riscv_pkg.sv | 12 +
 rtl/register_file.sv | 60 ++++++
 tb/tb_register_file.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 constants for the integer datapath.
// Register-file parameter defaults are derived from these values.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int REG_ZERO   = 0;
  localparam int REG_SP     = 2;

  localparam logic [XLEN-1:0] SP_RESET = 32'h0000_0100;

endpackage

// File: rtl/register_file.sv
// Two-read / one-write integer register file; x0 is hardwired to zero, x2 resets to SP_INIT.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module register_file
  import riscv_pkg::*;
#(
  parameter int                DATA_W  = XLEN,
  parameter int                ADDR_W  = REG_ADDR_W,
  parameter logic [DATA_W-1:0] SP_INIT = DATA_W'(SP_RESET)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] A1,
  input  logic [ADDR_W-1:0] A2,
  input  logic [ADDR_W-1:0] A3,
  input  logic              WE3,
  input  logic [DATA_W-1:0] WD3,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2
);

  localparam int NREG = 1 << ADDR_W;

  // x0 has no storage: the array starts at index 1.
  logic [DATA_W-1:0] regs [1:NREG-1];

  logic wr_ok;
  assign wr_ok = WE3 && (A3 != ADDR_W'(REG_ZERO));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 1; i < NREG; i++) begin
        regs[i] <= (i == REG_SP) ? SP_INIT : '0;
      end
    end else if (wr_ok) begin
      for (int i = 1; i < NREG; i++) begin
        if (A3 == ADDR_W'(i)) regs[i] <= WD3;
      end
    end
  end

  function automatic logic [DATA_W-1:0] rd_reg(input logic [ADDR_W-1:0] a);
    if (a == ADDR_W'(REG_ZERO)) return '0;
    return regs[a];
  endfunction

`ifdef REGFILE_BYPASS_EN
  always_comb begin
    RD1 = rd_reg(A1);
    RD2 = rd_reg(A2);
    if (wr_ok && (A1 == A3)) RD1 = WD3;
    if (wr_ok && (A2 == A3)) RD2 = WD3;
  end
`else
  always_comb begin
    RD1 = rd_reg(A1);
    RD2 = rd_reg(A2);
  end
`endif

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: reference array model checked every cycle plus literal directed checks.
// Build with REGFILE_BYPASS_EN defined to exercise the forwarding variant.
module tb_register_file;

  logic        clk;
  logic        rst;
  logic [4:0]  A1, A2, A3;
  logic        WE3;
  logic [31:0] WD3;
  logic [31:0] RD1, RD2;

  register_file dut (
    .clk(clk), .rst(rst),
    .A1(A1), .A2(A2), .A3(A3),
    .WE3(WE3), .WD3(WD3),
    .RD1(RD1), .RD2(RD2)
  );

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Architectural state: 32 registers, x0 kept at zero.
  logic [31:0] model [32];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) model[i] = (i == 2) ? 32'h100 : 32'h0;
    end else if (WE3 && A3 != 5'd0) begin
      model[A3] = WD3;
    end
  end

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (BYPASS && rst && WE3 && A3 != 5'd0 && a == A3) return WD3;
    return model[a];
  endfunction

  int    n_chk = 0;
  int    n_fail = 0;
  bit    chk_on = 1'b0;
  int    lit_seq = 0;
  int    lit_seen = 0;
  string lit_nm;
  logic [31:0] lit_e1, lit_e2;
  bit    lit_two;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %08h expected %08h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      cmp("model_rd1", RD1, exp_rd(A1));
      cmp("model_rd2", RD2, exp_rd(A2));
    end
    if (lit_seq != lit_seen) begin
      lit_seen = lit_seq;
      cmp({lit_nm, "_rd1"}, RD1, lit_e1);
      if (lit_two) cmp({lit_nm, "_rd2"}, RD2, lit_e2);
    end
  end

  // Request a literal check, evaluated at the next falling edge.
  task automatic lit(input string nm, input logic [31:0] e1, input bit two, input logic [31:0] e2);
    lit_nm  = nm;
    lit_e1  = e1;
    lit_e2  = e2;
    lit_two = two;
    lit_seq++;
    @(negedge clk);
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    WE3 = 1'b1; A3 = a; WD3 = d;
    step();
    WE3 = 1'b0;
  endtask

  initial begin
    rst = 1'b1; WE3 = 1'b0; A1 = '0; A2 = '0; A3 = '0; WD3 = '0;
    #1 rst = 1'b0;
    #1 chk_on = 1'b1;

    // Reset contents while held in reset
    for (int i = 0; i < 32; i++) begin
      A1 = 5'(i);
      lit("reset_sweep", (i == 2) ? 32'h100 : 32'h0, 1'b0, 32'h0);
    end
    step();
    rst = 1'b1;

    // Basic write then read on both ports
    wr(5'd5, 32'hDEADBEEF);
    A1 = 5'd5; A2 = 5'd5;
    lit("write_read_x5", 32'hDEADBEEF, 1'b1, 32'hDEADBEEF);

    // x0 write is discarded
    A1 = 5'd0; A2 = 5'd0;
    wr(5'd0, 32'hFFFFFFFF);
    lit("x0_protect", 32'h0, 1'b1, 32'h0);

    // Same-cycle read/write of x7
    wr(5'd7, 32'h1);
    WE3 = 1'b1; A3 = 5'd7; WD3 = 32'h2; A1 = 5'd7; A2 = 5'd0;
    lit("hazard_same_cycle", BYPASS ? 32'h2 : 32'h1, 1'b1, 32'h0);
    step();
    WE3 = 1'b0;
    lit("hazard_next_cycle", 32'h2, 1'b0, 32'h0);

    // WE3 low leaves x9 untouched
    wr(5'd9, 32'h0000_0ABC);
    A3 = 5'd9; WD3 = 32'h1234;
    for (int c = 0; c < 3; c++) step();
    A1 = 5'd9;
    lit("we3_low_x9", 32'h0000_0ABC, 1'b0, 32'h0);

    // Asynchronous reset between edges
    wr(5'd3, 32'h55);
    A1 = 5'd3; A2 = 5'd2;
    lit("x3_before_reset", 32'h55, 1'b1, 32'h100);
    @(posedge clk);
    #3 rst = 1'b0;
    lit("x3_async_reset", 32'h0, 1'b1, 32'h100);

    // Write coincident with an edge under reset is dropped
    WE3 = 1'b1; A3 = 5'd4; WD3 = 32'h77;
    step();
    WE3 = 1'b0;
    rst = 1'b1;
    A1 = 5'd4; A2 = 5'd2;
    lit("reset_dominates_write", 32'h0, 1'b1, 32'h100);

    // Fill all registers, then cross-read pairs
    for (int i = 0; i < 32; i++) wr(5'(i), 32'h0101_0101 * i + 32'hA5);
    for (int i = 0; i < 32; i++) begin
      A1 = 5'(i); A2 = 5'(31 - i);
      step();
    end
    A1 = 5'd10; A2 = 5'd10;
    lit("fill_x10_pair", 32'h0A0A_0AAF, 1'b1, 32'h0A0A_0AAF);

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
